// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: the 64-bit word type plus
// the access-size, strobe and FSM state encodings, and the size/offset helpers.
package common;
    typedef logic [63:0] word_t;
endpackage

package pipes;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t LSU_IDLE = 2'd0;
    localparam lsu_state_t LSU_BUS  = 2'd1;
    localparam lsu_state_t LSU_RESP = 2'd2;

    function automatic strobe_t strobe_for(msize_t size, logic [2:0] offset);
        case (size)
            MSIZE1:  return strobe_t'(8'h01) << offset;
            MSIZE2:  return strobe_t'(8'h03) << offset;
            MSIZE4:  return strobe_t'(8'h0F) << offset;
            default: return strobe_t'(8'hFF);
        endcase
    endfunction

    function automatic logic is_misaligned(msize_t size, logic [2:0] offset);
        case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return offset[0] != 1'b0;
            MSIZE4:  return offset[1:0] != 2'b00;
            default: return offset != 3'b000;
        endcase
    endfunction
endpackage

// File: rtl/dmem_lsu_if.sv
// Pipeline-side and memory-side signals of the load/store unit; the LSU is the
// master, the MEM stage plus data memory together form the slave side.
interface dmem_lsu_if;
    import common::*;
    import pipes::*;

    logic    req_valid;
    logic    req_ready;
    logic    req_write;
    msize_t  req_size;
    logic    req_unsigned;
    word_t   req_addr;
    word_t   req_wdata;
    logic    resp_valid;
    word_t   resp_rdata;
    logic    resp_error;
    logic    stall;

    logic    mem_valid;
    logic    mem_ready;
    logic    mem_write;
    word_t   mem_addr;
    strobe_t mem_strobe;
    word_t   mem_wdata;
    word_t   mem_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, stall,
        output mem_valid, mem_write, mem_addr, mem_strobe, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall,
        input  mem_valid, mem_write, mem_addr, mem_strobe, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_lsu_extract.sv
// Aligns raw 64-bit memory read data to the accessed byte lane and extends it
// to a full word; purely combinational so a cache path can reuse it.
module lsu_extract
    import common::*;
    import pipes::*;
(
    input  msize_t     size,
    input  logic       is_unsigned,
    input  logic [2:0] offset,
    input  word_t      rdata,
    output word_t      result
);
    word_t sh;

    always_comb begin
        sh     = rdata >> {offset, 3'b000};
        result = sh;
        case (size)
            MSIZE1:  result = is_unsigned ? word_t'(sh[7:0])  : {{56{sh[7]}},  sh[7:0]};
            MSIZE2:  result = is_unsigned ? word_t'(sh[15:0]) : {{48{sh[15]}}, sh[15:0]};
            MSIZE4:  result = is_unsigned ? word_t'(sh[31:0]) : {{32{sh[31]}}, sh[31:0]};
            default: result = sh;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator: accepts one pipeline access, issues one aligned 64-bit
// strobed bus request, and returns extended load data or an error pulse.
module dmem_lsu
    import common::*;
    import pipes::*;
#(
    parameter int unsigned MAX_WAIT = 255
)
(
    input logic        clk,
    input logic        rst_n,
    dmem_lsu_if.master bus
);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    lsu_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic       uns_q, uns_d;
    logic       err_q, err_d;
    msize_t     size_q, size_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    word_t      rdata_q, rdata_d;

    logic       in_idle, in_bus, in_resp;
    logic [2:0] offset;
    word_t      load_data;

    assign in_idle = (state_q == LSU_IDLE);
    assign in_bus  = (state_q == LSU_BUS);
    assign in_resp = (state_q == LSU_RESP);
    assign offset  = addr_q[2:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 8'd0;
                    if (is_misaligned(bus.req_size, bus.req_addr[2:0])) begin
                        state_d = LSU_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LSU_BUS;
                        err_d   = 1'b0;
                    end
                end
            end
            LSU_BUS: begin
                // A ready seen on the final permitted cycle still counts as success.
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    state_d = LSU_RESP;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == WAIT_LIMIT) begin
                        state_d = LSU_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= MSIZE1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    lsu_extract u_extract (
        .size        (size_q),
        .is_unsigned (uns_q),
        .offset      (offset),
        .rdata       (rdata_q),
        .result      (load_data)
    );

    // stall is masked by reset so an access held during reset does not freeze the pipe.
    assign bus.req_ready  = in_idle;
    assign bus.stall      = rst_n & ((in_idle & bus.req_valid) | in_bus);
    assign bus.resp_valid = in_resp;
    assign bus.resp_error = in_resp & err_q;
    assign bus.resp_rdata = (in_resp && !err_q && !write_q) ? load_data : '0;

    assign bus.mem_valid  = in_bus;
    assign bus.mem_write  = in_bus & write_q;
    assign bus.mem_addr   = in_bus ? {addr_q[63:3], 3'b000} : '0;
    assign bus.mem_strobe = in_bus ? strobe_for(size_q, offset) : '0;
    assign bus.mem_wdata  = in_bus ? (wdata_q << {offset, 3'b000}) : '0;
endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized accesses,
// compared every cycle against a byte-level behavioural model of the LSU.
module tb_dmem_lsu;
    import common::*;
    import pipes::*;

    localparam int TB_MAX_WAIT = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic chk_en;

    logic    exp_ready, exp_stall, exp_mem_valid, exp_mem_write, exp_resp_valid, exp_resp_error;
    word_t   exp_addr, exp_wdata, exp_rdata;
    strobe_t exp_strobe;

    word_t   obs_rdata, obs_addr, obs_wdata;
    logic    obs_error, obs_write;
    strobe_t obs_strobe;
    int      bus_seen;

    dmem_lsu_if lsu_bus ();

    dmem_lsu #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lsu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_misaligned(int sz, word_t addr);
        return (addr % word_t'(1 << sz)) != 0;
    endfunction

    function automatic strobe_t m_strobe(int sz, word_t addr);
        strobe_t s;
        int a = int'(addr % 8);
        int n = 1 << sz;
        s = '0;
        for (int i = 0; i < 8; i++) s[i] = (i >= a) && (i < a + n);
        return s;
    endfunction

    function automatic word_t m_wdata(word_t w, word_t addr);
        return w << (8 * int'(addr % 8));
    endfunction

    function automatic word_t m_load(int sz, bit uns, word_t addr, word_t rdata);
        word_t v, mask;
        int nbits = 8 << sz;
        v = rdata >> (8 * int'(addr % 8));
        if (nbits < 64) begin
            mask = (64'd1 << nbits) - 64'd1;
            v = v & mask;
            if (!uns && v[nbits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h expected=0x%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setIdle();
        exp_ready      = 1'b1;
        exp_stall      = lsu_bus.req_valid;
        exp_mem_valid  = 1'b0;
        exp_mem_write  = 1'b0;
        exp_resp_valid = 1'b0;
        exp_resp_error = 1'b0;
        exp_rdata      = '0;
    endtask

    task automatic setBus(input logic wr, input int sz, input word_t addr, input word_t wdata);
        exp_ready      = 1'b0;
        exp_stall      = 1'b1;
        exp_mem_valid  = 1'b1;
        exp_mem_write  = wr;
        exp_addr       = addr & ~word_t'(7);
        exp_strobe     = m_strobe(sz, addr);
        exp_wdata      = m_wdata(wdata, addr);
        exp_resp_valid = 1'b0;
        exp_resp_error = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("req_ready",  64'(lsu_bus.req_ready),  64'(exp_ready));
            checkOutput("stall",      64'(lsu_bus.stall),      64'(exp_stall));
            checkOutput("mem_valid",  64'(lsu_bus.mem_valid),  64'(exp_mem_valid));
            checkOutput("resp_valid", 64'(lsu_bus.resp_valid), 64'(exp_resp_valid));
            if (exp_mem_valid) begin
                checkOutput("mem_write",  64'(lsu_bus.mem_write),  64'(exp_mem_write));
                checkOutput("mem_addr",   lsu_bus.mem_addr,        exp_addr);
                checkOutput("mem_strobe", 64'(lsu_bus.mem_strobe), 64'(exp_strobe));
                checkOutput("mem_wdata",  lsu_bus.mem_wdata,       exp_wdata);
            end
            if (exp_resp_valid) begin
                checkOutput("resp_error", 64'(lsu_bus.resp_error), 64'(exp_resp_error));
                checkOutput("resp_rdata", lsu_bus.resp_rdata,      exp_rdata);
            end
            if (lsu_bus.mem_valid) begin
                bus_seen++;
                obs_addr   = lsu_bus.mem_addr;
                obs_strobe = lsu_bus.mem_strobe;
                obs_wdata  = lsu_bus.mem_wdata;
                obs_write  = lsu_bus.mem_write;
            end
            if (lsu_bus.resp_valid) begin
                obs_rdata = lsu_bus.resp_rdata;
                obs_error = lsu_bus.resp_error;
            end
        end
    end

    // Called at posedge+1 of the cycle in which the access is presented.
    task automatic applyStimulus(input logic wr, input msize_t sz, input logic uns, input word_t addr,
                                 input word_t wdata, input int delay, input word_t rdata);
        logic err;
        bit   done;
        int   k;
        bus_seen  = 0;
        obs_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        obs_error = 1'b0;
        lsu_bus.req_valid    = 1'b1;
        lsu_bus.req_write    = wr;
        lsu_bus.req_size     = sz;
        lsu_bus.req_unsigned = uns;
        lsu_bus.req_addr     = addr;
        lsu_bus.req_wdata    = wdata;
        lsu_bus.mem_ready    = 1'b0;
        lsu_bus.mem_rdata    = {$urandom(), $urandom()};
        setIdle();
        @(posedge clk); #1;
        lsu_bus.req_valid    = 1'b0;
        lsu_bus.req_write    = 1'($urandom_range(0, 1));
        lsu_bus.req_size     = msize_t'($urandom_range(0, 3));
        lsu_bus.req_unsigned = 1'($urandom_range(0, 1));
        lsu_bus.req_addr     = {$urandom(), $urandom()};
        lsu_bus.req_wdata    = {$urandom(), $urandom()};
        err = 1'b1;
        if (!m_misaligned(int'(sz), addr)) begin
            k = 0;
            done = 1'b0;
            while (!done) begin
                setBus(wr, int'(sz), addr, wdata);
                lsu_bus.mem_ready = (k == delay);
                lsu_bus.mem_rdata = (k == delay) ? rdata : {$urandom(), $urandom()};
                @(posedge clk); #1;
                if (k == delay) begin
                    done = 1'b1;
                    err  = 1'b0;
                end else if (k + 1 == TB_MAX_WAIT) begin
                    done = 1'b1;
                end
                k++;
            end
            lsu_bus.mem_ready = 1'b0;
        end
        exp_ready      = 1'b0;
        exp_stall      = 1'b0;
        exp_mem_valid  = 1'b0;
        exp_resp_valid = 1'b1;
        exp_resp_error = err;
        exp_rdata      = (err || wr) ? word_t'(0) : m_load(int'(sz), uns, addr, rdata);
        @(posedge clk); #1;
        setIdle();
    endtask

    task automatic resetMidBus();
        lsu_bus.req_valid = 1'b1;
        lsu_bus.req_write = 1'b0;
        lsu_bus.req_size  = MSIZE8;
        lsu_bus.req_addr  = 64'h6000;
        setIdle();
        @(posedge clk); #1;
        lsu_bus.req_valid = 1'b0;
        setBus(1'b0, 3, 64'h6000, lsu_bus.req_wdata);
        @(posedge clk); #1;
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("rst_mid_mem_valid",  64'(lsu_bus.mem_valid),  64'd0);
        checkOutput("rst_mid_stall",      64'(lsu_bus.stall),      64'd0);
        checkOutput("rst_mid_resp_valid", 64'(lsu_bus.resp_valid), 64'd0);
        checkOutput("rst_mid_req_ready",  64'(lsu_bus.req_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        setIdle();
        chk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int     gap, sz, delay;
        word_t  a;
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        lsu_bus.req_valid    = 1'b1;
        lsu_bus.req_write    = 1'b0;
        lsu_bus.req_size     = MSIZE1;
        lsu_bus.req_unsigned = 1'b0;
        lsu_bus.req_addr     = '0;
        lsu_bus.req_wdata    = '0;
        lsu_bus.mem_ready    = 1'b1;
        lsu_bus.mem_rdata    = '1;
        #2;
        checkOutput("rst_req_ready",  64'(lsu_bus.req_ready),  64'd1);
        checkOutput("rst_stall",      64'(lsu_bus.stall),      64'd0);
        checkOutput("rst_mem_valid",  64'(lsu_bus.mem_valid),  64'd0);
        checkOutput("rst_mem_write",  64'(lsu_bus.mem_write),  64'd0);
        checkOutput("rst_resp_valid", 64'(lsu_bus.resp_valid), 64'd0);
        checkOutput("rst_resp_error", 64'(lsu_bus.resp_error), 64'd0);
        checkOutput("rst_mem_addr",   lsu_bus.mem_addr,        64'd0);
        checkOutput("rst_mem_strobe", 64'(lsu_bus.mem_strobe), 64'd0);
        checkOutput("rst_mem_wdata",  lsu_bus.mem_wdata,       64'd0);
        checkOutput("rst_resp_rdata", lsu_bus.resp_rdata,      64'd0);
        @(posedge clk); #1;
        lsu_bus.req_valid = 1'b0;
        lsu_bus.mem_ready = 1'b0;
        rst_n  = 1'b1;
        setIdle();
        chk_en = 1'b1;
        @(posedge clk); #1;

        $display("[TB] byte store");
        applyStimulus(1'b1, MSIZE1, 1'b0, 64'h1005, 64'hAB, 0, 64'h0);
        checkOutput("bst_addr",     obs_addr,         64'h1000);
        checkOutput("bst_strobe",   64'(obs_strobe),  64'h20);
        checkOutput("bst_wdata",    obs_wdata,        64'h0000AB0000000000);
        checkOutput("bst_write",    64'(obs_write),   64'd1);
        checkOutput("bst_error",    64'(obs_error),   64'd0);
        checkOutput("bst_buscyc",   64'(bus_seen),    64'd1);

        $display("[TB] half loads");
        applyStimulus(1'b0, MSIZE2, 1'b0, 64'h2002, 64'h0, 1, 64'h0000000080010000);
        checkOutput("hld_signed",   obs_rdata, 64'hFFFFFFFFFFFF8001);
        applyStimulus(1'b0, MSIZE2, 1'b1, 64'h2002, 64'h0, 0, 64'h0000000080010000);
        checkOutput("hld_unsigned", obs_rdata, 64'h0000000000008001);

        $display("[TB] misaligned word");
        applyStimulus(1'b0, MSIZE4, 1'b0, 64'h3006, 64'h0, 0, 64'h0);
        checkOutput("mis_error",  64'(obs_error), 64'd1);
        checkOutput("mis_rdata",  obs_rdata,      64'd0);
        checkOutput("mis_buscyc", 64'(bus_seen),  64'd0);

        $display("[TB] timeout and last-cycle ready");
        applyStimulus(1'b0, MSIZE8, 1'b0, 64'h4000, 64'h0, 10, 64'h0);
        checkOutput("to_error",   64'(obs_error), 64'd1);
        checkOutput("to_buscyc",  64'(bus_seen),  64'd4);
        applyStimulus(1'b0, MSIZE8, 1'b0, 64'h4000, 64'h0, 3, 64'h0123456789ABCDEF);
        checkOutput("late_error", 64'(obs_error), 64'd0);
        checkOutput("late_rdata", obs_rdata,      64'h0123456789ABCDEF);

        $display("[TB] delayed dword store");
        applyStimulus(1'b1, MSIZE8, 1'b0, 64'h5008, 64'hFEDCBA9876543210, 3, 64'h0);
        checkOutput("dst_strobe", 64'(obs_strobe), 64'hFF);
        checkOutput("dst_wdata",  obs_wdata,       64'hFEDCBA9876543210);
        checkOutput("dst_buscyc", 64'(bus_seen),   64'd4);

        $display("[TB] reset mid-bus");
        resetMidBus();
        applyStimulus(1'b0, MSIZE4, 1'b0, 64'h7004, 64'h0, 1, 64'h123456789ABCDEF0);
        checkOutput("post_rst_rdata", obs_rdata, 64'h0000000012345678);

        $display("[TB] random accesses");
        for (int n = 0; n < 150; n++) begin
            sz    = int'($urandom_range(0, 3));
            delay = int'($urandom_range(0, 5));
            a     = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) a = a & ~((word_t'(1) << sz) - word_t'(1));
            applyStimulus(1'($urandom_range(0, 1)), msize_t'(sz), 1'($urandom_range(0, 1)), a,
                          {$urandom(), $urandom()}, delay, {$urandom(), $urandom()});
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
